// File: rtl/psum_writeback.sv
// psum_writeback: drains output-FIFO psum vectors into SRAM, overwrite or read-add-write.
// Define PSUM_WB_SAT_EN for per-lane saturating accumulation (default wraps).
module psum_writeback #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_BW = 11
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   acc_mode_i,
    input  logic [ADDR_BW-1:0]     base_addr_i,
    input  logic [ADDR_BW:0]       num_vec_i,
    input  logic                   ofifo_valid_i,
    input  logic [PSUM_BW*COL-1:0] ofifo_data_i,
    output logic                   ofifo_rd_o,
    output logic                   sram_cen_o,
    output logic                   sram_wen_o,
    output logic [ADDR_BW-1:0]     sram_addr_o,
    output logic [PSUM_BW*COL-1:0] sram_d_o,
    input  logic [PSUM_BW*COL-1:0] sram_q_i,
    output logic                   busy_o,
    output logic                   done_o
);
    typedef enum logic [2:0] {IDLE, FETCH, RDWAIT, WRITE, FIN} state_t;

    state_t                 state_q, state_d;
    logic                   acc_q, acc_d;
    logic [ADDR_BW:0]       num_q, num_d, cnt_q, cnt_d;
    logic [ADDR_BW-1:0]     addr_q, addr_d;
    logic [PSUM_BW*COL-1:0] hold_q, hold_d, sum_q, sum_d;

    function automatic logic [PSUM_BW-1:0] lane_add(input logic [PSUM_BW-1:0] a,
                                                    input logic [PSUM_BW-1:0] b);
`ifdef PSUM_WB_SAT_EN
        logic [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        // sign-extended sum disagreeing in its top two bits means overflow
        return (s[PSUM_BW] != s[PSUM_BW-1]) ? {s[PSUM_BW], {(PSUM_BW-1){~s[PSUM_BW]}}}
                                            : s[PSUM_BW-1:0];
`else
        return a + b;
`endif
    endfunction

    always_comb begin
        sum_d = sum_q;
        if (state_q == RDWAIT)
            for (int i = 0; i < COL; i++)
                sum_d[i*PSUM_BW +: PSUM_BW] = lane_add(hold_q[i*PSUM_BW +: PSUM_BW],
                                                       sram_q_i[i*PSUM_BW +: PSUM_BW]);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        hold_d     = hold_q;
        ofifo_rd_o = 1'b0;
        sram_cen_o = 1'b1;
        sram_wen_o = 1'b1;
        done_o     = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                acc_d   = acc_mode_i;
                num_d   = num_vec_i;
                addr_d  = base_addr_i;
                cnt_d   = '0;
                state_d = (num_vec_i == '0) ? FIN : FETCH;
            end
            FETCH: if (ofifo_valid_i) begin
                ofifo_rd_o = 1'b1;
                hold_d     = ofifo_data_i;
                sram_cen_o = ~acc_q;
                state_d    = acc_q ? RDWAIT : WRITE;
            end
            RDWAIT: state_d = WRITE;
            WRITE: begin
                sram_cen_o = 1'b0;
                sram_wen_o = 1'b0;
                addr_d     = addr_q + 1'b1;
                cnt_d      = cnt_q + 1'b1;
                state_d    = (cnt_d == num_q) ? FIN : FETCH;
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            num_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            sum_q   <= sum_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign sram_addr_o = addr_q;
    assign sram_d_o    = acc_q ? sum_q : hold_q;
endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback: directed vectors, write scoreboard checked by a negedge monitor.
module tb_psum_writeback;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, acc_mode = 1'b0;
    logic [10:0]  base_addr = '0, sram_addr;
    logic [11:0]  num_vec = '0;
    logic         ofifo_valid = 1'b0, ofifo_rd, sram_cen, sram_wen, busy, done;
    logic [127:0] ofifo_data = '0, sram_d, sram_q = '0;

    psum_writeback dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .acc_mode_i(acc_mode),
        .base_addr_i(base_addr), .num_vec_i(num_vec), .ofifo_valid_i(ofifo_valid),
        .ofifo_data_i(ofifo_data), .ofifo_rd_o(ofifo_rd), .sram_cen_o(sram_cen),
        .sram_wen_o(sram_wen), .sram_addr_o(sram_addr), .sram_d_o(sram_d),
        .sram_q_i(sram_q), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [10:0] addr; logic [127:0] data; } wr_t;
    wr_t          exp_q[$];
    logic [127:0] fifo_q[$];
    logic [127:0] mem [0:2047];
    int           wq[$];
    int           cyc = 0, tests = 0, fails = 0;
    int           done_cnt = 0, done_cyc = 0, rd_cnt = 0, rdc = 0;
    logic [10:0]  rda = '0;
    logic         rd_seen = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (!sram_cen && !sram_wen) mem[sram_addr] = sram_d;
        if (!sram_cen && sram_wen) sram_q <= mem[sram_addr];
    end

    task automatic upd();
        ofifo_valid = (fifo_q.size() > 0);
        ofifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [127:0] v);
        fifo_q.push_back(v);
        upd();
    endtask

    always begin
        @(negedge clk);
        rd_seen = ofifo_rd;
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        upd();
    end

    always @(negedge clk) begin
        wr_t e;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (ofifo_rd) begin
            rd_cnt++;
            tests++;
            if (!ofifo_valid) begin fails++; $display("FAIL pop_empty: ofifo_rd=1 while ofifo_valid=0 at cyc %0d", cyc); end
        end
        if (!sram_cen && sram_wen) begin rdc++; rda = sram_addr; end
        if (!sram_cen && !sram_wen) begin
            wq.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr %h data %h", sram_addr, sram_d);
            end else begin
                e = exp_q.pop_front();
                if (sram_addr !== e.addr || sram_d !== e.data) begin
                    fails++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             sram_addr, sram_d, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [10:0] a, input logic [127:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic acc, input logic [10:0] base, input logic [11:0] n,
                            output int s);
        @(posedge clk); #2;
        start = 1'b1; acc_mode = acc; base_addr = base; num_vec = n;
        @(posedge clk); #2;
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
        #2;
        tests++;
        if (done_cnt == d0) begin fails++; $display("FAIL %s: done timeout after %0d cycles", nm, budget); end
    endtask

    function automatic logic [127:0] vec_of(input int v);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(16*v + i);
        return r;
    endfunction

    initial begin
        int s, d0, r0, rc0;
        logic [127:0] exp_ovf;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        #12;
        chk("rst_cen", sram_cen, 1);
        chk("rst_wen", sram_wen, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_d", sram_d, 0);
        chk("rst_busy_done_rd", {busy, done, ofifo_rd}, 0);
        @(negedge clk); rst_n = 1'b1;

        // overwrite, 4 vectors, one write every 2 cycles
        wq.delete(); d0 = done_cnt; r0 = rd_cnt;
        for (int v = 0; v < 4; v++) begin push(vec_of(v)); expect_wr(11'h010 + 11'(v), vec_of(v)); end
        do_start(1'b0, 11'h010, 12'd4, s);
        chk("ow_busy", busy, 1);
        wait_done("ow_done", 40);
        repeat (3) @(posedge clk); #2;
        chk("ow_first_write_cyc", wq.size() > 0 ? wq[0] : -1, s + 1);
        for (int k = 1; k < 4; k++) chk("ow_write_spacing", wq.size() > k ? wq[k] - wq[k-1] : -1, 2);
        chk("ow_done_cyc", done_cyc, s + 8);
        chk("ow_done_pulses", done_cnt - d0, 1);
        chk("ow_pops", rd_cnt - r0, 4);
        chk("ow_busy_after", busy, 0);
        chk("ow_mem_012", mem[11'h012], vec_of(2));

        // accumulate, 100 + (-30) = 70
        mem[11'h020] = {8{16'd100}};
        wq.delete(); rc0 = rdc;
        push({8{16'hFFE2}});
        expect_wr(11'h020, {8{16'd70}});
        do_start(1'b1, 11'h020, 12'd1, s);
        wait_done("acc_done", 20);
        chk("acc_reads", rdc - rc0, 1);
        chk("acc_read_addr", rda, 11'h020);
        chk("acc_write_cyc", wq.size() > 0 ? wq[0] : -1, s + 2);
        chk("acc_done_cyc", done_cyc, s + 3);

        // lane overflow
        mem[11'h030] = {{6{16'h0005}}, 16'h8000, 16'h7FF0};
`ifdef PSUM_WB_SAT_EN
        exp_ovf = {{6{16'h0008}}, 16'h8000, 16'h7FFF};
`else
        exp_ovf = {{6{16'h0008}}, 16'h7FFF, 16'h8010};
`endif
        push({{6{16'h0003}}, 16'hFFFF, 16'h0020});
        expect_wr(11'h030, exp_ovf);
        do_start(1'b1, 11'h030, 12'd1, s);
        wait_done("ovf_done", 20);
        chk("ovf_mem", mem[11'h030], exp_ovf);

        // stall between vectors plus address wrap
        wq.delete(); r0 = rd_cnt;
        push(vec_of(5));
        expect_wr(11'h7FF, vec_of(5));
        expect_wr(11'h000, vec_of(6));
        do_start(1'b0, 11'h7FF, 12'd2, s);
        for (int k = 0; k < 20 && wq.size() == 0; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        chk("stall_busy", busy, 1);
        chk("stall_one_pop", rd_cnt - r0, 1);
        push(vec_of(6));
        wait_done("stall_done", 20);
        chk("stall_pops", rd_cnt - r0, 2);

        // num_vec = 0
        wq.delete(); rc0 = rdc; r0 = rd_cnt; d0 = done_cnt;
        do_start(1'b0, 11'h100, 12'd0, s);
        wait_done("zero_done", 10);
        chk("zero_done_cyc", done_cyc, s);
        chk("zero_no_sram", {32'(wq.size()), 32'(rdc - rc0), 32'(rd_cnt - r0)}, 0);

        // second start while busy ignored
        wq.delete(); rc0 = rdc; d0 = done_cnt;
        expect_wr(11'h040, vec_of(7));
        expect_wr(11'h041, vec_of(8));
        do_start(1'b0, 11'h040, 12'd2, s);
        repeat (2) @(posedge clk);
        do_start(1'b1, 11'h100, 12'd1, s);
        push(vec_of(7));
        push(vec_of(8));
        wait_done("busy_done", 30);
        repeat (6) @(posedge clk); #2;
        chk("busy_writes", wq.size(), 2);
        chk("busy_no_reads", rdc - rc0, 0);
        chk("busy_done_pulses", done_cnt - d0, 1);

        // reset during RDWAIT
        wq.delete();
        push(vec_of(9));
        do_start(1'b1, 11'h050, 12'd1, s);
        @(posedge clk); #2;
        chk("rdwait_busy", {busy, sram_cen}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cen_wen", {sram_cen, sram_wen}, 2'b11);
        chk("mid_rst_addr", sram_addr, 0);
        chk("mid_rst_d", sram_d, 0);
        chk("mid_rst_busy_done_rd", {busy, done, ofifo_rd}, 0);
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk); #2;
        chk("mid_rst_no_write", wq.size(), 0);
        chk("mid_rst_idle", busy, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
